// File: rtl/zstr_arb.sv
// zstr_arb: N-input round-robin arbiter merging z stream sources onto one sink.
// Define ZSTR_ARB_PKT_EN for packet-locked arbitration (adds s_lst/m_lst).
module zstr_arb #(
  parameter int   N  = 2,
  parameter int   BW = 1,
  parameter logic XZ = 1'bx,
  parameter int   SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_vld,
  input  logic [N*BW-1:0] s_bus,
  output logic [N-1:0]    s_rdy,
  output logic            m_vld,
  output logic [BW-1:0]   m_bus,
  input  logic            m_rdy,
  output logic [SW-1:0]   m_sel,
  output logic            m_gnt
`ifdef ZSTR_ARB_PKT_EN
  ,
  input  logic [N-1:0]    s_lst,
  output logic            m_lst
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [SW-1:0]        gnt, ptr, gnt_nx;
  logic [N-1:0][BW-1:0] bus_a;
  logic                 busy, cur_vld, xfer, rel, wdr;
  logic [SW:0]          pick_idle, pick_next;

  // First set bit of v at or after start (mod N); MSB flags a hit.
  function automatic logic [SW:0] pick(input logic [N-1:0] v, input logic [SW-1:0] start);
    logic [SW:0]   r;
    logic [SW-1:0] i_s;
    int            idx;
    r = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (int'(start) + k) % N;
      i_s = idx[SW-1:0];
      if (v[i_s]) r = {1'b1, i_s};
    end
    return r;
  endfunction

  assign bus_a     = s_bus;
  assign busy      = (state == BUSY);
  assign cur_vld   = s_vld[gnt];
  assign m_vld     = busy & cur_vld;
  assign m_bus     = m_vld ? bus_a[gnt] : {BW{XZ}};
  assign m_sel     = gnt;
  assign m_gnt     = busy;
  assign xfer      = m_vld & m_rdy;
  assign gnt_nx    = (int'(gnt) == N-1) ? '0 : gnt + 1'b1;
  assign pick_idle = pick(s_vld, ptr);
  assign pick_next = pick(s_vld, gnt_nx);

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign s_rdy[i] = busy && (int'(gnt) == i) && m_rdy;
  end

`ifdef ZSTR_ARB_PKT_EN
  // Grant is locked until the last beat of a packet; gaps mid-packet keep it.
  assign m_lst = busy & s_lst[gnt];
  assign rel   = xfer & m_lst;
  assign wdr   = 1'b0;
`else
  assign rel   = xfer;
  assign wdr   = ~cur_vld;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_idle[SW]) begin
          gnt   <= pick_idle[SW-1:0];
          state <= BUSY;
        end
        BUSY: if (rel) begin
          // Current owner competes again, but at lowest priority.
          ptr <= gnt_nx;
          if (pick_next[SW]) gnt <= pick_next[SW-1:0];
          else               state <= IDLE;
        end else if (wdr) begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zstr_arb.sv
// Self-checking bench for zstr_arb (N=4, BW=8): vector table, hand sequences, beat scoreboard.
module tb_zstr_arb;
  localparam int N = 4, BW = 8;

  logic          clk = 1'b0, rst = 1'b0;
  logic [N-1:0]  s_vld = '0, s_rdy;
  logic [N*BW-1:0] s_bus;
  logic          m_vld, m_rdy = 1'b0, m_gnt;
  logic [BW-1:0] m_bus;
  logic [1:0]    m_sel;
`ifdef ZSTR_ARB_PKT_EN
  logic [N-1:0]  s_lst = '0;
  logic          m_lst;
`endif

  zstr_arb #(.N(N), .BW(BW), .XZ(1'b1)) dut (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_bus(s_bus), .s_rdy(s_rdy),
    .m_vld(m_vld), .m_bus(m_bus), .m_rdy(m_rdy), .m_sel(m_sel), .m_gnt(m_gnt)
`ifdef ZSTR_ARB_PKT_EN
    , .s_lst(s_lst), .m_lst(m_lst)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0, xfer_cnt = 0;
  logic [9:0]  sbq[$];
  logic [31:0] b0;
  logic [9:0]  e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] beat(input int src);
    return {2'(src), b0[src*8 +: 8]};
  endfunction

  // Every completed beat must match the next expected {sel, bus}.
  always @(negedge clk) begin
    if (m_vld && m_rdy) begin
      xfer_cnt++;
      if (sbq.size() == 0) begin
        checks++; fails++;
        $display("FAIL sb_unexpected act_sel=%0d act_bus=%0h exp=none", m_sel, m_bus);
      end else begin
        e = sbq.pop_front();
        chk("sb_sel", 32'(m_sel), 32'(e[9:8]));
        chk("sb_bus", 32'(m_bus), 32'(e[7:0]));
      end
    end
  end

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic       e_vld;
    logic [1:0] e_sel;
    logic [3:0] e_srdy;
    logic [7:0] e_bus;
    logic       e_gnt;
  } vec_t;

  vec_t tv[9];

  initial begin
    b0    = 32'h77_A5_3C_11;
    s_bus = b0;
    //          vld     rdy  vld sel srdy     bus    gnt
    tv[0] = '{4'b0100, 1'b1, 0, 0, 4'b0000, 8'hFF, 0};  // idle, request seen
    tv[1] = '{4'b0100, 1'b1, 1, 2, 4'b0100, 8'hA5, 1};  // 1-cycle latency
    tv[2] = '{4'b0000, 1'b1, 0, 2, 4'b0100, 8'hFF, 1};  // withdraw
    tv[3] = '{4'b1001, 1'b1, 0, 2, 4'b0000, 8'hFF, 0};  // ptr=3 -> src3
    tv[4] = '{4'b1001, 1'b1, 1, 3, 4'b1000, 8'h77, 1};  // wrap to src0
    tv[5] = '{4'b1001, 1'b0, 1, 0, 4'b0000, 8'h11, 1};  // stall
    tv[6] = '{4'b1001, 1'b1, 1, 0, 4'b0001, 8'h11, 1};
    tv[7] = '{4'b0000, 1'b1, 0, 3, 4'b1000, 8'hFF, 1};
    tv[8] = '{4'b0000, 1'b1, 0, 3, 4'b0000, 8'hFF, 0};

    #12;
    chk("rst_m_vld", 32'(m_vld), 0);
    chk("rst_m_gnt", 32'(m_gnt), 0);
    chk("rst_s_rdy", 32'(s_rdy), 0);
    chk("rst_m_sel", 32'(m_sel), 0);
    chk("rst_m_bus", 32'(m_bus), 32'hFF);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

`ifndef ZSTR_ARB_PKT_EN
    foreach (tv[i]) begin
      s_vld = tv[i].vld; m_rdy = tv[i].rdy;
      if (tv[i].e_vld && tv[i].rdy) sbq.push_back({tv[i].e_sel, tv[i].e_bus});
      @(negedge clk);
      chk($sformatf("tv%0d_vld", i),  32'(m_vld), 32'(tv[i].e_vld));
      chk($sformatf("tv%0d_sel", i),  32'(m_sel), 32'(tv[i].e_sel));
      chk($sformatf("tv%0d_srdy", i), 32'(s_rdy), 32'(tv[i].e_srdy));
      chk($sformatf("tv%0d_bus", i),  32'(m_bus), 32'(tv[i].e_bus));
      chk($sformatf("tv%0d_gnt", i),  32'(m_gnt), 32'(tv[i].e_gnt));
      @(posedge clk); #1;
    end

    // Async reset while stalled in BUSY; ptr must restart at 0.
    s_vld = 4'b0100; m_rdy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("ar_busy", 32'(m_gnt), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_m_vld", 32'(m_vld), 0);
    chk("ar_s_rdy", 32'(s_rdy), 0);
    chk("ar_m_gnt", 32'(m_gnt), 0);
    @(posedge clk); #1;
    rst = 1'b1; s_vld = 4'b0101;
    @(negedge clk); chk("ar_idle", 32'(m_gnt), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("ar_regrant_sel", 32'(m_sel), 0);
    @(posedge clk); #1; s_vld = '0;
    @(posedge clk); #1;

    // Round robin: all request, one beat per cycle, 0,1,2,3,0,1.
    s_vld = 4'b1111; m_rdy = 1'b1; xfer_cnt = 0;
    foreach (tv[i]) if (i < 6) sbq.push_back(beat(i % 4));
    repeat (7) @(posedge clk);
    #1 s_vld = '0;
    chk("rr_beats", 32'(xfer_cnt), 6);
    @(posedge clk); #1;

    // Backpressure: src1 frozen for 5 cycles while src0 waits; ptr=2 -> src0 next.
    s_vld = 4'b0010; m_rdy = 1'b0;
    @(posedge clk); #1; s_vld = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_sel", 32'(m_sel), 1);
      chk("bp_bus", 32'(m_bus), 32'h3C);
      chk("bp_srdy", 32'(s_rdy), 0);
      @(posedge clk); #1;
    end
    sbq.push_back(beat(1)); sbq.push_back(beat(0)); m_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("bp_next_sel", 32'(m_sel), 0);
    @(posedge clk); #1; s_vld = '0;
    @(posedge clk); #1;

    // Withdrawal of src3; ptr stays 1 so {3,0} picks 3.
    s_vld = 4'b1000; m_rdy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("wd_sel", 32'(m_sel), 3);
    @(posedge clk); #1; s_vld = '0;
    @(negedge clk); chk("wd_m_vld", 32'(m_vld), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("wd_idle", 32'(m_gnt), 0);
    s_vld = 4'b1001;
    @(posedge clk); #1;
    @(negedge clk); chk("wd_ptr_sel", 32'(m_sel), 3);
    @(posedge clk); #1; sbq.push_back(beat(3)); m_rdy = 1'b1;
    @(posedge clk); #1; s_vld = '0;
    @(posedge clk); #1;
`else
    // Packet lock: src0 keeps grant for 3 beats across a gap; src1 follows.
    s_vld = 4'b0011; s_lst = '0; m_rdy = 1'b1;
    repeat (3) sbq.push_back(beat(0));
    sbq.push_back(beat(1));
    @(posedge clk); #1;
    @(negedge clk); chk("pk_b1_sel", 32'(m_sel), 0);
    @(posedge clk); #1; s_vld = 4'b0010;
    @(negedge clk); chk("pk_gap_sel", 32'(m_sel), 0); chk("pk_gap_vld", 32'(m_vld), 0);
    @(posedge clk); #1; s_vld = 4'b0011;
    @(negedge clk); chk("pk_b2_sel", 32'(m_sel), 0);
    @(posedge clk); #1; s_lst = 4'b0001;
    @(negedge clk); chk("pk_b3_sel", 32'(m_sel), 0); chk("pk_b3_lst", 32'(m_lst), 1);
    @(posedge clk); #1; s_lst = '0;
    @(negedge clk); chk("pk_next_sel", 32'(m_sel), 1); chk("pk_next_vld", 32'(m_vld), 1);
    @(posedge clk); #1; s_vld = '0;
    @(posedge clk); #1;
`endif

    chk("sb_left", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/zstr_arb.md
Name: zstr_arb

Overview:
- N-input round-robin arbiter that shares one z stream sink between several z stream sources (e.g. multiple zstr_src instances feeding one DUT port).
- Registers its grant, forwards the granted source's valid/bus/ready, and rotates priority after every transfer.
- Used in benches and RTL wherever one z stream consumer serves multiple producers.

Parameters:
- N, 2, number of requesting z stream inputs (N >= 2).
- BW, 1, z stream bus width per input.
- XZ, 1'bx, idle value driven on every bit of m_bus when m_vld=0.
- SW, $clog2(N), width of the grant index.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous and active-low.
- s_vld  input  N  per-source transfer valid.
- s_bus  input  N*BW  per-source bus; source i occupies bits [i*BW +: BW].
- s_rdy  output  N  per-source transfer ready.
- m_vld  output  1  merged transfer valid.
- m_bus  output  BW  merged bus.
- m_rdy  input  1  sink ready.
- m_sel  output  SW  index of the currently granted source.
- m_gnt  output  1  grant active (state BUSY).

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE, gnt=0, ptr=0.
  - Outputs: m_gnt=0, m_vld=0, s_rdy=0, m_sel=0, m_bus=XZ.
  - Reset mid-transfer drops the grant immediately; any in-flight beat is not transferred.
- State IDLE:
  - m_vld=0 and all s_rdy=0.
  - If any s_vld=1, select the first i with s_vld[i]=1, searching from ptr upward modulo N.
  - Register gnt=i and go to BUSY. Arbitration latency is 1 cycle from request to m_vld.
- State BUSY:
  - m_vld = s_vld[gnt], m_bus = s_bus[gnt], s_rdy[gnt] = m_rdy; all other s_rdy=0.
  - m_sel=gnt, m_gnt=1.
  - Transfer event: m_vld & m_rdy.
- On a transfer:
  - ptr <= (gnt+1) mod N.
  - Re-arbitrate in the same cycle over s_vld, searching from (gnt+1) mod N. The granted source's own s_vld is included, at lowest priority.
  - If a requester is found, register the new gnt and stay in BUSY. Back-to-back transfers therefore sustain 1 beat/cycle when the same source keeps winning.
  - If no requester is found, go to IDLE.
- Switching between different sources costs no bubble; the new gnt is registered at the transfer edge.
- If s_vld[gnt]=0 in BUSY with no transfer (source withdrew): go to IDLE and leave ptr unchanged.
- While m_vld=1 and m_rdy=0, the grant is frozen. gnt, m_bus and m_sel must not change until the transfer.
- Priority search wraps: from ptr=N-1 the order is N-1, 0, 1, ...
- With only one active requester, it is re-granted every cycle with no bubble.
- m_bus=XZ whenever m_vld=0.

Optional Feature:
- Macro ZSTR_ARB_PKT_EN enables packet-locked arbitration.
- With the macro defined:
  - Extra ports: s_lst (input, N) and m_lst (output, 1); m_lst = s_lst[gnt] in BUSY, 0 otherwise.
  - After a transfer with m_lst=0, gnt is held, state stays BUSY and there is no re-arbitration.
  - Release and rotation happen only on a transfer with m_lst=1.
  - The withdraw rule is disabled: BUSY persists while s_vld[gnt]=0 mid-packet.
- Without the macro: no lst ports; every beat is an independent arbitration unit as described above.

Test Plan:
- Reset then single request (N=4, BW=8): s_vld=4'b0100, s_bus[2]=8'hA5, m_rdy=1.
  - Cycle 1: m_vld=0.
  - Cycle 2: m_vld=1, m_bus=8'hA5, m_sel=2, s_rdy=4'b0100.
  - Then ptr=3.
- Round-robin fairness: all s_vld=1 continuously, m_rdy=1 → m_sel sequence 0,1,2,3,0,1, one transfer per cycle after the first grant.
- Backpressure: grant src1 with m_bus=8'h3C and m_rdy=0 for 5 cycles while src0 also requests.
  - m_sel=1 and m_bus=8'h3C stable for all 5 cycles; s_rdy=0.
  - Transfer on m_rdy=1, next m_sel=2 or 0 per ptr.
- Withdrawal: src3 granted, s_vld[3] drops before m_rdy → next cycle IDLE, m_vld=0, ptr unchanged.
- Async reset mid-BUSY: rst=0 between clock edges → m_vld, s_rdy, m_gnt are 0 immediately. After release, arbitration restarts from ptr=0.
- With ZSTR_ARB_PKT_EN: src0 sends a 3-beat packet (lst on beat 3) while src1 requests.
  - m_sel=0 for all 3 beats, including one cycle with s_vld[0]=0 mid-packet.
  - m_sel=1 the cycle after the lst transfer.
